// File: rtl/chute_brique_if.sv
// Bus between the falling-brick engine and the joystick controller:
// column/fast-drop requests in, brick row, stack heights and game status out.
interface chute_brique_if;
    logic [1:0] col;
    logic       boutonBas;
    logic [2:0] row;
    logic [2:0] hauteurGauche;
    logic [2:0] hauteurCentre;
    logic [2:0] hauteurDroite;
    logic       briquePosee;
    logic       gameOver;
    logic [7:0] score;

    modport master (
        output col, boutonBas,
        input  row, hauteurGauche, hauteurCentre, hauteurDroite,
        input  briquePosee, gameOver, score
    );

    modport slave (
        input  col, boutonBas,
        output row, hauteurGauche, hauteurCentre, hauteurDroite,
        output briquePosee, gameOver, score
    );
endinterface

// File: rtl/chute_brique.sv
// Falling-brick engine for the three-column brick game: gravity, stacking, respawn, score, game over.
// Optional line clear is compiled in when LIGNE_COMPLETE_EN is defined.
module chute_brique #(
    parameter int DIV_CHUTE = 25_000_000,
    parameter int SPAWN_ROW = 7
) (
    input  logic         clk,
    input  logic         reset,
    chute_brique_if.slave bus
);

    localparam int             CW       = (DIV_CHUTE > 1) ? $clog2(DIV_CHUTE) : 1;
    localparam logic [CW-1:0]  LIM_NORM = CW'(DIV_CHUTE - 1);
    localparam logic [CW-1:0]  LIM_FAST = CW'((DIV_CHUTE >> 2) - 1);
    localparam logic [2:0]     SPAWN_R  = 3'(SPAWN_ROW);

    typedef enum logic [2:0] {
        CHUTE    = 3'd0,
        POSE     = 3'd1,
        SPAWN    = 3'd2,
`ifdef LIGNE_COMPLETE_EN
        CLEAR    = 3'd4,
`endif
        GAMEOVER = 3'd3
    } state_t;

    function automatic logic [2:0] sat_inc3(input logic [2:0] v);
        return (v == 3'd7) ? v : v + 3'd1;
    endfunction

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [3:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {5'b0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    // Column 3 is not a real column; the controller means centre.
    function automatic logic [1:0] col_map(input logic [1:0] c);
        return (c == 2'd3) ? 2'd1 : c;
    endfunction

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    row_q, row_d;
    logic [2:0]    h_q [0:2];
    logic [2:0]    h_d [0:2];
    logic [7:0]    score_q, score_d;
    logic          pose_q, pose_d;
    logic [1:0]    colsel_q, colsel_d;

    logic [CW-1:0] limit;
    logic          tick;
    logic [1:0]    col_now;
    logic [2:0]    h_new;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= CHUTE;
            cnt_q    <= '0;
            row_q    <= SPAWN_R;
            h_q[0]   <= 3'd0;
            h_q[1]   <= 3'd0;
            h_q[2]   <= 3'd0;
            score_q  <= 8'd0;
            pose_q   <= 1'b0;
            colsel_q <= 2'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            row_q    <= row_d;
            h_q[0]   <= h_d[0];
            h_q[1]   <= h_d[1];
            h_q[2]   <= h_d[2];
            score_q  <= score_d;
            pose_q   <= pose_d;
            colsel_q <= colsel_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        row_d    = row_q;
        h_d[0]   = h_q[0];
        h_d[1]   = h_q[1];
        h_d[2]   = h_q[2];
        score_d  = score_q;
        pose_d   = 1'b0;
        colsel_d = colsel_q;

        // The fast limit is compared live, so pressing the button late still ticks at once.
        limit   = bus.boutonBas ? LIM_FAST : LIM_NORM;
        tick    = (cnt_q >= limit);
        col_now = col_map(bus.col);
        h_new   = sat_inc3(h_q[colsel_q]);

        case (state_q)
            CHUTE: begin
                if (tick) begin
                    cnt_d = '0;
                    if (row_q == h_q[col_now]) begin
                        state_d  = POSE;
                        colsel_d = col_now;
                    end else if (row_q != 3'd0) begin
                        row_d = row_q - 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            POSE: begin
                h_d[colsel_q] = h_new;
                score_d       = sat_add8(score_q, 4'd1);
                pose_d        = 1'b1;
                if (h_new >= SPAWN_R) begin
                    state_d = GAMEOVER;
                end else begin
`ifdef LIGNE_COMPLETE_EN
                    if ((h_d[0] != 3'd0) && (h_d[1] != 3'd0) && (h_d[2] != 3'd0))
                        state_d = CLEAR;
                    else
                        state_d = SPAWN;
`else
                    state_d = SPAWN;
`endif
                end
            end

`ifdef LIGNE_COMPLETE_EN
            CLEAR: begin
                for (int i = 0; i < 3; i++) begin
                    if (h_q[i] != 3'd0)
                        h_d[i] = h_q[i] - 3'd1;
                end
                score_d = sat_add8(score_q, 4'd4);
                state_d = SPAWN;
            end
`endif

            SPAWN: begin
                row_d   = SPAWN_R;
                cnt_d   = '0;
                state_d = CHUTE;
            end

            GAMEOVER: begin
                state_d = GAMEOVER;
            end

            default: begin
                state_d = CHUTE;
            end
        endcase
    end

    assign bus.row           = row_q;
    assign bus.hauteurGauche = h_q[0];
    assign bus.hauteurCentre = h_q[1];
    assign bus.hauteurDroite = h_q[2];
    assign bus.briquePosee   = pose_q;
    assign bus.gameOver      = (state_q == GAMEOVER);
    assign bus.score         = score_q;

endmodule

// File: tb/tb_chute_brique.sv
// Directed bench for chute_brique with DIV_CHUTE=4, SPAWN_ROW=7.
module tb_chute_brique;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    chute_brique_if bus ();

    chute_brique #(.DIV_CHUTE(4), .SPAWN_ROW(7)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_pulse(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (bus.briquePosee === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        bus.col = 2'd0;
        bus.boutonBas = 1'b0;
        do_reset();
        checks++; if (bus.row !== 3'd7) begin errors++; $display("FAIL reset_row got %0d want 7", bus.row); end
        checks++; if (bus.hauteurGauche !== 3'd0 || bus.hauteurCentre !== 3'd0 || bus.hauteurDroite !== 3'd0) begin
            errors++; $display("FAIL reset_heights got %0d/%0d/%0d want 0/0/0", bus.hauteurGauche, bus.hauteurCentre, bus.hauteurDroite); end
        checks++; if (bus.score !== 8'd0) begin errors++; $display("FAIL reset_score got %0d want 0", bus.score); end
        checks++; if (bus.briquePosee !== 1'b0 || bus.gameOver !== 1'b0) begin
            errors++; $display("FAIL reset_flags got pose=%b go=%b want 0 0", bus.briquePosee, bus.gameOver); end
    endtask

    task automatic test_fall_land();
        bus.col = 2'd0;
        bus.boutonBas = 1'b0;
        do_reset();
        for (int r = 6; r >= 0; r--) begin
            repeat (3) @(negedge clk);
            checks++; if (bus.row !== 3'(r + 1)) begin errors++; $display("FAIL fall_hold got %0d want %0d", bus.row, r + 1); end
            @(negedge clk);
            checks++; if (bus.row !== 3'(r)) begin errors++; $display("FAIL fall_step got %0d want %0d", bus.row, r); end
        end
        repeat (4) @(negedge clk);
        checks++; if (bus.row !== 3'd0 || bus.briquePosee !== 1'b0) begin
            errors++; $display("FAIL land_tick got row=%0d pose=%b want 0 0", bus.row, bus.briquePosee); end
        @(negedge clk);
        checks++; if (bus.briquePosee !== 1'b1) begin errors++; $display("FAIL land_pulse got %b want 1", bus.briquePosee); end
        checks++; if (bus.hauteurGauche !== 3'd1 || bus.hauteurCentre !== 3'd0) begin
            errors++; $display("FAIL land_height got G=%0d C=%0d want 1 0", bus.hauteurGauche, bus.hauteurCentre); end
        checks++; if (bus.score !== 8'd1) begin errors++; $display("FAIL land_score got %0d want 1", bus.score); end
        @(negedge clk);
        checks++; if (bus.row !== 3'd7 || bus.briquePosee !== 1'b0) begin
            errors++; $display("FAIL respawn got row=%0d pose=%b want 7 0", bus.row, bus.briquePosee); end
    endtask

    task automatic test_game_over();
        bit ok;
        bus.col = 2'd1;
        bus.boutonBas = 1'b0;
        do_reset();
        for (int i = 1; i <= 7; i++) begin
            wait_pulse(ok);
            checks++; if (!ok) begin errors++; $display("FAIL go_pulse_timeout brick %0d got none want pulse", i); end
            checks++; if (bus.hauteurCentre !== 3'(i) || bus.score !== 8'(i)) begin
                errors++; $display("FAIL go_stack got C=%0d score=%0d want %0d", bus.hauteurCentre, bus.score, i); end
        end
        checks++; if (bus.gameOver !== 1'b1 || bus.row !== 3'd6) begin
            errors++; $display("FAIL go_enter got go=%b row=%0d want 1 6", bus.gameOver, bus.row); end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if (bus.row !== 3'd6 || bus.hauteurCentre !== 3'd7 || bus.score !== 8'd7 ||
                bus.gameOver !== 1'b1 || bus.briquePosee !== 1'b0) begin
                errors++;
                $display("FAIL go_frozen cycle %0d got row=%0d C=%0d score=%0d go=%b pose=%b want 6 7 7 1 0",
                         c, bus.row, bus.hauteurCentre, bus.score, bus.gameOver, bus.briquePosee);
            end
        end
        do_reset();
        checks++; if (bus.row !== 3'd7 || bus.hauteurCentre !== 3'd0 || bus.score !== 8'd0 || bus.gameOver !== 1'b0) begin
            errors++; $display("FAIL go_reset got row=%0d C=%0d score=%0d go=%b want 7 0 0 0",
                               bus.row, bus.hauteurCentre, bus.score, bus.gameOver); end
    endtask

    task automatic test_fast_drop();
        bus.col = 2'd0;
        bus.boutonBas = 1'b1;
        do_reset();
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checks++; if (bus.row !== 3'(7 - k)) begin errors++; $display("FAIL fast_step got %0d want %0d", bus.row, 7 - k); end
        end
        bus.boutonBas = 1'b0;
        for (int r = 3; r >= 2; r--) begin
            repeat (3) @(negedge clk);
            checks++; if (bus.row !== 3'(r + 1)) begin errors++; $display("FAIL slow_hold got %0d want %0d", bus.row, r + 1); end
            @(negedge clk);
            checks++; if (bus.row !== 3'(r)) begin errors++; $display("FAIL slow_step got %0d want %0d", bus.row, r); end
        end
    endtask

    task automatic test_col3();
        bit ok;
        bus.col = 2'd3;
        bus.boutonBas = 1'b0;
        do_reset();
        wait_pulse(ok);
        checks++; if (!ok) begin errors++; $display("FAIL col3_timeout got none want pulse"); end
        checks++; if (bus.hauteurGauche !== 3'd0 || bus.hauteurCentre !== 3'd1 || bus.hauteurDroite !== 3'd0) begin
            errors++; $display("FAIL col3_heights got %0d/%0d/%0d want 0/1/0", bus.hauteurGauche, bus.hauteurCentre, bus.hauteurDroite); end
    endtask

    task automatic test_line();
        bit ok;
        bus.boutonBas = 1'b1;
        bus.col = 2'd0;
        do_reset();
        for (int c = 0; c < 3; c++) begin
            bus.col = 2'(c);
            wait_pulse(ok);
            checks++; if (!ok) begin errors++; $display("FAIL line_timeout col %0d got none want pulse", c); end
        end
        checks++; if (bus.hauteurGauche !== 3'd1 || bus.hauteurCentre !== 3'd1 || bus.hauteurDroite !== 3'd1 || bus.score !== 8'd3) begin
            errors++; $display("FAIL line_pose got %0d/%0d/%0d score=%0d want 1/1/1 3",
                               bus.hauteurGauche, bus.hauteurCentre, bus.hauteurDroite, bus.score); end
        @(negedge clk);
`ifdef LIGNE_COMPLETE_EN
        checks++; if (bus.hauteurGauche !== 3'd0 || bus.hauteurCentre !== 3'd0 || bus.hauteurDroite !== 3'd0 || bus.score !== 8'd7) begin
            errors++; $display("FAIL line_clear got %0d/%0d/%0d score=%0d want 0/0/0 7",
                               bus.hauteurGauche, bus.hauteurCentre, bus.hauteurDroite, bus.score); end
        checks++; if (bus.row !== 3'd0) begin errors++; $display("FAIL line_clear_row got %0d want 0", bus.row); end
        @(negedge clk);
        checks++; if (bus.row !== 3'd7) begin errors++; $display("FAIL line_respawn got %0d want 7", bus.row); end
`else
        checks++; if (bus.hauteurGauche !== 3'd1 || bus.hauteurCentre !== 3'd1 || bus.hauteurDroite !== 3'd1 || bus.score !== 8'd3) begin
            errors++; $display("FAIL line_noclear got %0d/%0d/%0d score=%0d want 1/1/1 3",
                               bus.hauteurGauche, bus.hauteurCentre, bus.hauteurDroite, bus.score); end
        checks++; if (bus.row !== 3'd7) begin errors++; $display("FAIL line_respawn got %0d want 7", bus.row); end
`endif
    endtask

    task automatic test_reset_midfall();
        bit ok;
        bit seen;
        bus.boutonBas = 1'b0;
        bus.col = 2'd2;
        do_reset();
        for (int b = 0; b < 2; b++) begin
            wait_pulse(ok);
            checks++; if (!ok) begin errors++; $display("FAIL mid_timeout brick %0d got none want pulse", b); end
        end
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (bus.row === 3'd4) seen = 1'b1;
        end
        checks++; if (!seen || bus.hauteurDroite !== 3'd2) begin
            errors++; $display("FAIL mid_setup got row=%0d D=%0d want 4 2", bus.row, bus.hauteurDroite); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (bus.row !== 3'd7 || bus.hauteurGauche !== 3'd0 || bus.hauteurCentre !== 3'd0 || bus.hauteurDroite !== 3'd0) begin
            errors++; $display("FAIL mid_reset got row=%0d %0d/%0d/%0d want 7 0/0/0",
                               bus.row, bus.hauteurGauche, bus.hauteurCentre, bus.hauteurDroite); end
        checks++; if (bus.score !== 8'd0 || bus.briquePosee !== 1'b0 || bus.gameOver !== 1'b0) begin
            errors++; $display("FAIL mid_reset_flags got score=%0d pose=%b go=%b want 0 0 0",
                               bus.score, bus.briquePosee, bus.gameOver); end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.col = 2'd0;
        bus.boutonBas = 1'b0;
        test_reset();
        test_fall_land();
        test_game_over();
        test_fast_drop();
        test_col3();
        test_line();
        test_reset_midfall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
